// File: rtl/pkt_fifo_if.sv
// Writer/reader handshake bundle for pkt_fifo.
// The master modport drives the flit writer inputs and rd_next; the slave modport is the FIFO.
interface pkt_fifo_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 3
);
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_last;
    logic              wr_abort;
    logic              wr_ack;
    logic              wr_drop;
    logic [CNT_W-1:0]  capacity;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              rd_next;
    logic [CNT_W-1:0]  pkt_count;

    modport master (
        output wr_valid, wr_data, wr_last, wr_abort, rd_next,
        input  wr_ack, wr_drop, capacity, rd_valid, rd_data, rd_last, pkt_count
    );

    modport slave (
        input  wr_valid, wr_data, wr_last, wr_abort, rd_next,
        output wr_ack, wr_drop, capacity, rd_valid, rd_data, rd_last, pkt_count
    );
endinterface

// File: rtl/pkt_fifo.sv
// Packet FIFO: flits become readable only after their whole packet commits.
// Optional PKT_FIFO_SEQ_CHECK_EN enables the per-flit sequence bit check on wr_data[0].
//
// state   | meaning
// IDLE    | no packet open
// OPEN    | packet partially written, not yet visible to the reader
// DISCARD | packet was dropped; ignore flits until its last flit or an abort
module pkt_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 5,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input logic       clk,
    input logic       rst,
    pkt_fifo_if.slave bus
);
    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPEN    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] commit_ptr_q, commit_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] com_cnt_q, com_cnt_d;
    logic [CNT_W-1:0] tent_cnt_q, tent_cnt_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic             ack_q, ack_d;
    logic             drop_q, drop_d;
    logic [DATA_W:0]  mem [DEPTH];

    logic push, commit, rollback, pop, pop_last, full, seq_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
    endfunction

    // Full is judged on the tentative count before any same-cycle pop.
    assign full     = (tent_cnt_q == DEPTH_C);
    assign pop      = bus.rd_next && (com_cnt_q != '0);
    assign pop_last = pop && mem[rd_ptr_q][DATA_W];

`ifdef PKT_FIFO_SEQ_CHECK_EN
    logic seq_q, seq_d;

    assign seq_ok = (bus.wr_data[0] == ((state_q == OPEN) ? seq_q : 1'b0));

    always_comb begin
        seq_d = seq_q;
        if (push) begin
            seq_d = ~bus.wr_data[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q <= 1'b0;
        end else begin
            seq_q <= seq_d;
        end
    end
`else
    assign seq_ok = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        push     = 1'b0;
        commit   = 1'b0;
        rollback = 1'b0;
        ack_d    = 1'b0;
        drop_d   = 1'b0;
        case (state_q)
            IDLE, OPEN: begin
                if ((state_q == OPEN) && bus.wr_abort) begin
                    rollback = 1'b1;
                    drop_d   = 1'b1;
                    state_d  = IDLE;
                end else if (bus.wr_valid) begin
                    if (full || !seq_ok) begin
                        rollback = 1'b1;
                        drop_d   = 1'b1;
                        state_d  = bus.wr_last ? IDLE : DISCARD;
                    end else begin
                        push = 1'b1;
                        if (bus.wr_last) begin
                            commit  = 1'b1;
                            ack_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = OPEN;
                        end
                    end
                end
            end
            DISCARD: begin
                if (bus.wr_abort || (bus.wr_valid && bus.wr_last)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (rollback) begin
            wr_ptr_d = commit_ptr_q;
        end else if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        commit_ptr_d = commit ? ptr_inc(wr_ptr_q) : commit_ptr_q;
        rd_ptr_d     = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        // On commit every tentative flit plus the one arriving now becomes committed.
        com_cnt_d = com_cnt_q;
        if (commit) begin
            com_cnt_d = tent_cnt_q + CNT_W'(1);
        end
        if (pop) begin
            com_cnt_d = com_cnt_d - CNT_W'(1);
        end

        tent_cnt_d = tent_cnt_q;
        if (rollback) begin
            tent_cnt_d = com_cnt_q;
        end else if (push) begin
            tent_cnt_d = tent_cnt_q + CNT_W'(1);
        end
        if (pop) begin
            tent_cnt_d = tent_cnt_d - CNT_W'(1);
        end

        pkt_cnt_d = pkt_cnt_q;
        if (commit && !pop_last) begin
            pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
        end else if (!commit && pop_last) begin
            pkt_cnt_d = pkt_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rd_ptr_q     <= '0;
            commit_ptr_q <= '0;
            wr_ptr_q     <= '0;
            com_cnt_q    <= '0;
            tent_cnt_q   <= '0;
            pkt_cnt_q    <= '0;
            ack_q        <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            com_cnt_q    <= com_cnt_d;
            tent_cnt_q   <= tent_cnt_d;
            pkt_cnt_q    <= pkt_cnt_d;
            ack_q        <= ack_d;
            drop_q       <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {bus.wr_last, bus.wr_data};
        end
    end

    assign bus.wr_ack    = ack_q;
    assign bus.wr_drop   = drop_q;
    assign bus.capacity  = DEPTH_C - tent_cnt_q;
    assign bus.rd_valid  = (com_cnt_q != '0);
    assign bus.rd_data   = mem[rd_ptr_q][DATA_W-1:0];
    assign bus.rd_last   = mem[rd_ptr_q][DATA_W];
    assign bus.pkt_count = pkt_cnt_q;
endmodule

// File: doc/pkt_fifo.md
# pkt_fifo

Parametrised synchronous packet FIFO between a flit writer and a flit reader on the network-interface path. The writer pushes multi-flit packets. Flits become visible to the reader only once the whole packet is committed, so the reader never sees a partial packet. An open packet is rolled back cleanly on abort, on overflow, or (optionally) on a sequence error. It reports free capacity to the writer and complete-packet count to the reader.

## Interface
Parameters:
- DATA_W, 32 — flit width in bits.
- DEPTH, 5 — flit storage entries; any value 2..255, not restricted to a power of two.
- CNT_W, $clog2(DEPTH+1) — width of the occupancy and capacity counters.

Ports:
- clk  in  1  — single clock; all state changes on its rising edge.
- rst  in  1  — synchronous, active-high reset.
- wr_valid  in  1  — a flit is presented this cycle.
- wr_data  in  DATA_W  — flit payload.
- wr_last  in  1  — the presented flit ends its packet.
- wr_abort  in  1  — discard the open packet.
- wr_ack  out  1  — one-cycle pulse: packet committed.
- wr_drop  out  1  — one-cycle pulse: open packet rolled back.
- capacity  out  CNT_W  — free entries, equal to DEPTH minus the tentative occupancy.
- rd_valid  out  1  — at least one committed flit is available.
- rd_data  out  DATA_W  — head flit.
- rd_last  out  1  — head flit ends its packet.
- rd_next  in  1  — pop the head flit; ignored when rd_valid=0.
- pkt_count  out  CNT_W  — committed packets not yet fully read.

## Operation
- Storage: circular memory of DEPTH entries of {last, data}.
- Pointers: rd_ptr, commit_ptr, wr_ptr, each wrapping from DEPTH-1 to 0.
- Occupancy counters: committed count and tentative count.
- State machine:
  - IDLE: no packet open.
    - Accepted flit with wr_last=1: written and committed at once (a single-flit packet).
    - Accepted flit with wr_last=0: written; go to OPEN.
  - OPEN: flits are written at wr_ptr.
    - Accepted flit with wr_last=1: commit_ptr←wr_ptr+1, pulse wr_ack, go to IDLE.
    - wr_abort=1: wr_ptr←commit_ptr, tentative count←committed count, pulse wr_drop, go to IDLE. If wr_valid is also high, that flit is discarded.
  - DISCARD: every flit is ignored until one with wr_last=1, then go to IDLE. wr_abort=1 also returns to IDLE.
- wr_abort in IDLE: no effect, no pulse.
- Overflow:
  - Condition: wr_valid=1 while tentative count == DEPTH, evaluated before any same-cycle pop.
  - Action: roll back as for abort and pulse wr_drop.
  - Next state: IDLE if the overflowing flit has wr_last=1, else DISCARD.
  - A packet longer than DEPTH therefore never commits.
- Read side:
  - rd_valid = (committed count > 0).
  - rd_data and rd_last come from mem[rd_ptr].
  - rd_next pops one flit. A popped flit with last=1 decrements pkt_count.
- pkt_count: +1 on commit, −1 on popping a last flit; a commit and a last-pop in the same cycle leave it unchanged.
- Arithmetic:
  - All counters are CNT_W wide.
  - Pointer increment is an explicit compare-and-wrap at DEPTH-1.
  - Rollback is a pointer copy, never a subtraction.

## Timing
- Reset values:
  - All pointers and counters 0; state IDLE.
  - wr_ack=0, wr_drop=0, rd_valid=0, pkt_count=0, capacity=DEPTH.
  - Memory contents are not reset.
- Write latency: a flit is stored at the edge where it is accepted. capacity reflects it in the following cycle.
- Commit latency: wr_ack is high in the cycle after the last flit's edge. rd_valid and pkt_count update in that same cycle.
- Simultaneous push and pop: both take effect. capacity changes by the net amount.
- Rollback and capacity: the rollback edge restores capacity to DEPTH minus the committed count. It does not disturb reads.
- rst asserted mid-packet: the open packet and all stored data are lost; no wr_drop pulse.

## Configuration
- PKT_FIFO_SEQ_CHECK_EN defined:
  - Each flit carries a sequence bit in wr_data[0], expected 0 on the first flit of a packet and toggling on each subsequent flit.
  - A mismatch in OPEN or IDLE rolls back the open packet, pulses wr_drop, and enters DISCARD (or IDLE if wr_last=1). The mismatching flit is not stored.
- Undefined: wr_data[0] is plain payload and no check is made.

## Test plan
- DEPTH=5, reset → capacity=5, rd_valid=0, pkt_count=0.
- Write 3-flit packet 0xA2C2/0xC2A3/0xE2C4 (last on third) → wr_ack one cycle after third; pkt_count=1; reader pops 0xA2C2, 0xC2A3, 0xE2C4 with rd_last on third; pkt_count=0.
- Write 2 flits, then wr_abort → wr_drop pulse, capacity back to 5, rd_valid never rose.
- Write 6-flit packet into DEPTH=5 → wr_drop on sixth flit; remaining flits ignored until wr_last; capacity=5; then a 1-flit packet 0x1234 commits normally.
- Wrap-around:
  - Fill with 5-flit packet; pop 3.
  - Write 2-flit packet 0xABCD/0xB1F4 plus simultaneous pop → pointers wrap.
  - Reader gets remaining 2 flits, then 0xABCD, 0xB1F4; pkt_count goes 2→1→0.
- With PKT_FIFO_SEQ_CHECK_EN: flits 0x0, 0x0 (bit0 should be 1) → wr_drop on second flit, nothing committed.
